// File: rtl/frame_uart_streamer.sv
`default_nettype none
// frame_uart_streamer: walks a WIDTH x HEIGHT word buffer and streams each word MSB-first to a byte UART.
// Optional 4-byte frame header is built in when FRAME_UART_HEADER_EN is defined.
module frame_uart_streamer #(
    parameter int WIDTH         = 40,
    parameter int HEIGHT        = 30,
    parameter int X_BITS        = 6,
    parameter int Y_BITS        = 5,
    parameter int WORD_BYTES    = 4,
    parameter int HOLDOFF_BITS  = 13,
    parameter int DEBOUNCE_BITS = 14
) (
    input  logic                    clock_i,
    input  logic                    areset_i,
    input  logic                    trigger_i,
    input  logic                    continuous_i,
    output logic [X_BITS-1:0]       read_x_o,
    output logic [Y_BITS-1:0]       read_y_o,
    input  logic [8*WORD_BYTES-1:0] read_data_i,
    input  logic                    uart_busy_i,
    output logic                    uart_write_o,
    output logic [7:0]              uart_data_o,
    output logic                    sending_o,
    output logic                    frame_done_o
);

    localparam int                Z_BITS = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam logic [X_BITS-1:0] X_LAST = X_BITS'(WIDTH - 1);
    localparam logic [Y_BITS-1:0] Y_LAST = Y_BITS'(HEIGHT - 1);
    localparam logic [Z_BITS-1:0] Z_LAST = Z_BITS'(WORD_BYTES - 1);

`ifdef FRAME_UART_HEADER_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_DATA = 2'd1, S_HEADER = 2'd2} state_t;
    localparam state_t S_FIRST = S_HEADER;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_DATA = 2'd1} state_t;
    localparam state_t S_FIRST = S_DATA;
`endif

    state_t                   state_q, state_d;
    logic                     trig_meta_q, trig_s_q;
    logic [DEBOUNCE_BITS-1:0] debounce_q, debounce_d;
    logic [HOLDOFF_BITS-1:0]  holdoff_q, holdoff_d;
    logic [X_BITS-1:0]        x_q, x_d;
    logic [Y_BITS-1:0]        y_q, y_d;
    logic [Z_BITS-1:0]        z_q, z_d;
    logic                     write_q, write_d;
    logic [7:0]               data_q, data_d;
    logic                     done_q, done_d;
`ifdef FRAME_UART_HEADER_EN
    logic [1:0]               hdr_q, hdr_d;
    logic [7:0]               hdr_byte;
`endif

    logic       deb_sat, hold_sat, start, strobe;
    logic [7:0] data_byte;

    assign deb_sat  = &debounce_q;
    assign hold_sat = &holdoff_q;
    assign start    = trig_s_q && deb_sat && (state_q == S_IDLE);
    // The previous-cycle write check keeps the strobe one cycle wide even if the UART raises busy late.
    assign strobe   = (state_q != S_IDLE) && hold_sat && !uart_busy_i && !write_q;

    always_comb begin
        data_byte = 8'h00;
        for (int i = 0; i < WORD_BYTES; i++) begin
            if (z_q == Z_BITS'(i)) begin
                data_byte = read_data_i[8*(WORD_BYTES-i)-1 -: 8];
            end
        end
    end

`ifdef FRAME_UART_HEADER_EN
    always_comb begin
        case (hdr_q)
            2'd0:    hdr_byte = 8'hA5;
            2'd1:    hdr_byte = 8'h5A;
            2'd2:    hdr_byte = 8'(WIDTH);
            default: hdr_byte = 8'(HEIGHT);
        endcase
    end
`endif

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        z_d        = z_q;
        write_d    = 1'b0;
        data_d     = data_q;
        done_d     = 1'b0;
        debounce_d = trig_s_q ? '0 : (deb_sat ? debounce_q : debounce_q + DEBOUNCE_BITS'(1));
        holdoff_d  = uart_busy_i ? '0 : (hold_sat ? holdoff_q : holdoff_q + HOLDOFF_BITS'(1));
`ifdef FRAME_UART_HEADER_EN
        hdr_d      = hdr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    x_d     = '0;
                    y_d     = '0;
                    z_d     = '0;
                    state_d = S_FIRST;
`ifdef FRAME_UART_HEADER_EN
                    hdr_d   = 2'd0;
`endif
                end
            end
`ifdef FRAME_UART_HEADER_EN
            S_HEADER: begin
                if (strobe) begin
                    write_d = 1'b1;
                    data_d  = hdr_byte;
                    hdr_d   = hdr_q + 2'd1;
                    if (hdr_q == 2'd3) begin
                        state_d = S_DATA;
                    end
                end
            end
`endif
            S_DATA: begin
                if (strobe) begin
                    write_d = 1'b1;
                    data_d  = data_byte;
                    if (z_q != Z_LAST) begin
                        z_d = z_q + Z_BITS'(1);
                    end else begin
                        z_d = '0;
                        if (x_q != X_LAST) begin
                            x_d = x_q + X_BITS'(1);
                        end else begin
                            x_d = '0;
                            if (y_q != Y_LAST) begin
                                y_d = y_q + Y_BITS'(1);
                            end else begin
                                y_d     = '0;
                                done_d  = 1'b1;
                                state_d = continuous_i ? S_FIRST : S_IDLE;
`ifdef FRAME_UART_HEADER_EN
                                hdr_d   = 2'd0;
`endif
                            end
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock_i or posedge areset_i) begin
        if (areset_i) begin
            state_q     <= S_IDLE;
            trig_meta_q <= 1'b0;
            trig_s_q    <= 1'b0;
            debounce_q  <= '0;
            holdoff_q   <= '0;
            x_q         <= '0;
            y_q         <= '0;
            z_q         <= '0;
            write_q     <= 1'b0;
            data_q      <= 8'h00;
            done_q      <= 1'b0;
`ifdef FRAME_UART_HEADER_EN
            hdr_q       <= 2'd0;
`endif
        end else begin
            state_q     <= state_d;
            trig_meta_q <= trigger_i;
            trig_s_q    <= trig_meta_q;
            debounce_q  <= debounce_d;
            holdoff_q   <= holdoff_d;
            x_q         <= x_d;
            y_q         <= y_d;
            z_q         <= z_d;
            write_q     <= write_d;
            data_q      <= data_d;
            done_q      <= done_d;
`ifdef FRAME_UART_HEADER_EN
            hdr_q       <= hdr_d;
`endif
        end
    end

    assign read_x_o     = x_q;
    assign read_y_o     = y_q;
    assign uart_write_o = write_q;
    assign uart_data_o  = data_q;
    assign sending_o    = (state_q != S_IDLE);
    assign frame_done_o = done_q;

endmodule
`default_nettype wire

// File: doc/frame_uart_streamer.md
# frame_uart_streamer

Parametrised frame-dump engine that walks a downsampled frame buffer word by word and serialises each word MSB-first into bytes for a byte-wide UART transmitter. It sits in the 12 MHz system domain between the downsample read port and the UART, replacing hard-wired 40x30x4-byte dump logic. It adds generic geometry and word size, single-shot or continuous dumping, abort on reset, and an optional frame header.

## Interface
- WIDTH, 40, words per line
- HEIGHT, 30, lines per frame
- X_BITS, 6, width of read_x; must satisfy 2^X_BITS ≥ WIDTH
- Y_BITS, 5, width of read_y; must satisfy 2^Y_BITS ≥ HEIGHT
- WORD_BYTES, 4, bytes per read_data word (1..8)
- HOLDOFF_BITS, 13, idle-gap counter width; gap = 2^HOLDOFF_BITS−1 cycles
- DEBOUNCE_BITS, 14, trigger debounce counter width
- clock  in  1  system clock; the only clock
- areset  in  1  asynchronous, active-high reset
- trigger  in  1  raw button level, active high; asynchronous to clock
- continuous  in  1  1 = restart at frame end, 0 = single shot
- read_x  out  X_BITS  buffer column address
- read_y  out  Y_BITS  buffer line address
- read_data  in  8*WORD_BYTES  buffer word; registered source, valid 1 cycle after address
- uart_busy  in  1  UART transmitting
- uart_write  out  1  one-cycle byte strobe
- uart_data  out  8  byte to send, valid while uart_write is high
- sending  out  1  dump in progress
- frame_done  out  1  one-cycle pulse after last byte of a frame is strobed

## Operation
- trigger passes through a 2-flop synchroniser (trig_s). Debounce counter clears while trig_s=1, else increments and saturates at all-ones.
- Start condition: trig_s=1, debounce counter saturated, state IDLE. Trigger while not IDLE is ignored.
- States: IDLE -> (HEADER if macro set) -> DATA -> IDLE, or DATA -> DATA when continuous=1 at frame end.
- On start: read_x=0, read_y=0, byte index z=0, sending=1.
- Holdoff counter clears while uart_busy=1, else increments and saturates.
- Strobe rule: uart_write=1 for one cycle only when holdoff saturated, uart_busy=0, and uart_write was 0 the previous cycle.
- DATA byte for index z: read_data[8*(WORD_BYTES−z)−1 -: 8] (z=0 is MSB byte).
- On each strobe z increments. When z=WORD_BYTES−1: z->0 and read_x increments; when read_x=WIDTH−1: read_x->0 and read_y increments.
- After the strobe of (x=WIDTH−1, y=HEIGHT−1, z=WORD_BYTES−1): frame_done pulses next cycle, and read_x, read_y and z return to 0. With continuous=1 (sampled on that strobe) the state stays DATA, otherwise it goes to IDLE with sending=0.
- Byte order is z innermost, then x, then y. The total is WIDTH*HEIGHT*WORD_BYTES data bytes per frame.
- Address changes happen only on the strobe cycle. The next strobe needs holdoff saturation after UART completion, so read_data is always settled.

## Timing
- Reset values: read_x=0, read_y=0, uart_write=0, uart_data=0, sending=0, frame_done=0, state IDLE, z=0, holdoff=0, debounce=0.
- areset mid-frame aborts immediately. No strobe is issued until a fresh debounced trigger arrives.
- Start-to-first-strobe: ≥2^HOLDOFF_BITS−1 cycles after the last uart_busy high or after reset.
- uart_data is registered together with uart_write and held until the next strobe.
- If uart_busy rises in the same cycle the holdoff saturates, no strobe is issued.
- Deasserting continuous mid-frame takes effect at the end of the current frame. Frames are never truncated.

## Configuration
- FRAME_UART_HEADER_EN defined: after start, the HEADER state strobes 4 bytes, 0xA5, 0x5A, WIDTH[7:0], HEIGHT[7:0], before the first data byte. The header uses the same strobe rule and is repeated at each continuous-mode restart.
- Not defined: there is no HEADER state, and the first strobe after start is data byte (0,0,z=0).

## Test plan
- Params WIDTH=3, HEIGHT=2, WORD_BYTES=2, HOLDOFF_BITS=3, DEBOUNCE_BITS=3. read_data = {x,y} pattern 0xXXYY. Debounced trigger -> exactly 12 strobes, bytes 0x00,0x00,0x01,0x00,0x02,0x00,0x00,0x01,… ending 0x02,0x01. Then one frame_done pulse, sending=0.
- Model uart_busy high for 10 cycles after each strobe -> consecutive strobes are spaced ≥ 10+7 cycles, and uart_write is never high for 2 cycles.
- Trigger bounce (high pulse after only 4 low cycles, and re-trigger during a dump) -> no second start; the byte count stays 12.
- continuous=1 -> after frame_done, byte 13 is 0x00 from (0,0). Drop continuous mid-frame 2 -> exactly 24 bytes, then IDLE.
- Assert areset at byte 5 -> all outputs are 0 next cycle and no strobes occur with trigger held low.
- FRAME_UART_HEADER_EN defined -> stream begins 0xA5,0x5A,0x03,0x02, followed by the 12 data bytes.
